// File: rtl/z80_ld_hl_ind_nn_seq_pkg.sv
// Shared Z80 definitions for the LD HL,(nn) sequencer: M-cycle types, opcode, FSM states.
package z80_ld_hl_ind_nn_seq_pkg;

  typedef enum logic [1:0] {
    CYCLE_NONE     = 2'd0,
    CYCLE_M1       = 2'd1,
    CYCLE_RDWR_MEM = 2'd2
  } cycle_t;

  localparam logic [7:0] OPC_LD_HL_IND_NN = 8'h2A;

  // Encoded so the state value equals the reported M-cycle number.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    M1_FETCH = 3'd1,
    M2_NLO   = 3'd2,
    M3_NHI   = 3'd3,
    M4_MLO   = 3'd4,
    M5_MHI   = 3'd5
  } state_t;

  function automatic logic [2:0] mcycle_of(input state_t s);
    return 3'(s);
  endfunction

endpackage

// File: rtl/z80_ld_hl_ind_nn_seq_if.sv
// Z80 memory read bus: registered address/strobes from the CPU side, data and WAIT from memory.
interface z80_ld_hl_ind_nn_seq_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_rdata;
  logic        bus_wait_n;
  logic        bus_m1_n;
  logic        bus_mreq_n;
  logic        bus_rd_n;

  modport master (
    output bus_addr, bus_m1_n, bus_mreq_n, bus_rd_n,
    input  bus_rdata, bus_wait_n
  );

  modport slave (
    input  bus_addr, bus_m1_n, bus_mreq_n, bus_rd_n,
    output bus_rdata, bus_wait_n
  );
endinterface

// File: rtl/z80_ld_hl_ind_nn_seq_bus_mcycle.sv
// One Z80 read M-cycle (M1: 4 T-states, memory read: 3) with registered address/strobes.
// T2 repeats while bus_wait_n=0; rd_vld marks the edge that samples data, cyc_end the last T-state.
module z80_bus_mcycle
  import z80_ld_hl_ind_nn_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cyc_go,
  input  cycle_t      cyc_type,
  input  logic [15:0] cyc_addr,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_wait_n,
  output logic [15:0] bus_addr,
  output logic        bus_m1_n,
  output logic        bus_mreq_n,
  output logic        bus_rd_n,
  output logic [2:0]  tstate,
  output logic        rd_vld,
  output logic [7:0]  rd_dat,
  output logic        cyc_end
);

  cycle_t      type_q, type_d;
  logic [2:0]  tstate_q, tstate_d;
  logic [15:0] addr_q, addr_d;
  logic        m1_n_q, m1_n_d;
  logic        mreq_n_q, mreq_n_d;
  logic        rd_n_q, rd_n_d;
  logic        active;
  logic        strobe_on;

  always_comb begin
    active  = (type_q != CYCLE_NONE);
    rd_vld  = active && (tstate_q == 3'd2) && bus_wait_n;
    rd_dat  = bus_rdata;
    cyc_end = ((type_q == CYCLE_M1) && (tstate_q == 3'd4)) ||
              ((type_q == CYCLE_RDWR_MEM) && (tstate_q == 3'd3));
  end

  always_comb begin
    type_d   = type_q;
    tstate_d = tstate_q;
    addr_d   = addr_q;
    if (cyc_go) begin
      type_d   = cyc_type;
      tstate_d = 3'd1;
      addr_d   = cyc_addr;
    end else if (cyc_end) begin
      type_d   = CYCLE_NONE;
      tstate_d = 3'd0;
      addr_d   = 16'h0000;
    end else if (active && !((tstate_q == 3'd2) && !bus_wait_n)) begin
      tstate_d = tstate_q + 3'd1;
    end
    // Strobes are low exactly in T1-T2 of the cycle being entered.
    strobe_on = (type_d != CYCLE_NONE) && ((tstate_d == 3'd1) || (tstate_d == 3'd2));
    mreq_n_d  = !strobe_on;
    rd_n_d    = !strobe_on;
    m1_n_d    = !(strobe_on && (type_d == CYCLE_M1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      type_q   <= CYCLE_NONE;
      tstate_q <= 3'd0;
      addr_q   <= 16'h0000;
      m1_n_q   <= 1'b1;
      mreq_n_q <= 1'b1;
      rd_n_q   <= 1'b1;
    end else begin
      type_q   <= type_d;
      tstate_q <= tstate_d;
      addr_q   <= addr_d;
      m1_n_q   <= m1_n_d;
      mreq_n_q <= mreq_n_d;
      rd_n_q   <= rd_n_d;
    end
  end

  assign bus_addr   = addr_q;
  assign bus_m1_n   = m1_n_q;
  assign bus_mreq_n = mreq_n_q;
  assign bus_rd_n   = rd_n_q;
  assign tstate     = tstate_q;

endmodule

// File: rtl/z80_ld_hl_ind_nn_seq.sv
// LD HL,(nn) sequencer: opcode fetch, read nn, then load L/H from (nn)/(nn+1) over five M-cycles.
// Latency 16 cycles start-to-done without waits; bus_wait_n stretches T2 of any M-cycle.
module z80_ld_hl_ind_nn_seq
  import z80_ld_hl_ind_nn_seq_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [15:0]                   ip_in,
  z80_ld_hl_ind_nn_seq_if.master        bus,
  output logic                          busy,
  output logic                          done,
  output logic                          illegal,
  output logic [7:0]                    reg_h_out,
  output logic [7:0]                    reg_l_out,
  output logic [15:0]                   reg_ip_out,
  output logic [2:0]                    mcycle,
  output logic [2:0]                    tstate
);

  state_t      state_q, state_d;
  logic [15:0] ip_q, ip_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  nlo_q, nlo_d;
  logic [7:0]  nhi_q, nhi_d;
  logic [7:0]  ltmp_q, ltmp_d;
  logic [7:0]  reg_h_q, reg_h_d;
  logic [7:0]  reg_l_q, reg_l_d;
  logic [15:0] reg_ip_q, reg_ip_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        busy_q, busy_d;
  logic [2:0]  mcycle_q, mcycle_d;

  logic        cyc_go;
  cycle_t      cyc_type;
  logic [15:0] cyc_addr;
  logic        rd_vld;
  logic [7:0]  rd_dat;
  logic        cyc_end;

  z80_bus_mcycle u_mcycle (
    .clk        (clk),
    .reset_n    (reset_n),
    .cyc_go     (cyc_go),
    .cyc_type   (cyc_type),
    .cyc_addr   (cyc_addr),
    .bus_rdata  (bus.bus_rdata),
    .bus_wait_n (bus.bus_wait_n),
    .bus_addr   (bus.bus_addr),
    .bus_m1_n   (bus.bus_m1_n),
    .bus_mreq_n (bus.bus_mreq_n),
    .bus_rd_n   (bus.bus_rd_n),
    .tstate     (tstate),
    .rd_vld     (rd_vld),
    .rd_dat     (rd_dat),
    .cyc_end    (cyc_end)
  );

  always_comb begin
    state_d   = state_q;
    ip_d      = ip_q;
    op_d      = op_q;
    nlo_d     = nlo_q;
    nhi_d     = nhi_q;
    ltmp_d    = ltmp_q;
    reg_h_d   = reg_h_q;
    reg_l_d   = reg_l_q;
    reg_ip_d  = reg_ip_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    cyc_go    = 1'b0;
    cyc_type  = CYCLE_RDWR_MEM;
    cyc_addr  = 16'h0000;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = M1_FETCH;
          ip_d     = ip_in;
          cyc_go   = 1'b1;
          cyc_type = CYCLE_M1;
          cyc_addr = ip_in;
        end
      end
      M1_FETCH: begin
        if (rd_vld) op_d = rd_dat;
        // Opcode is known from T3 on, so the illegal pulse lands in T4.
        illegal_d = (tstate == 3'd3) && (op_q != OPC_LD_HL_IND_NN);
        if (cyc_end) begin
          if (op_q == OPC_LD_HL_IND_NN) begin
            state_d  = M2_NLO;
            cyc_go   = 1'b1;
            cyc_addr = ip_q + 16'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      M2_NLO: begin
        if (rd_vld) nlo_d = rd_dat;
        if (cyc_end) begin
          state_d  = M3_NHI;
          cyc_go   = 1'b1;
          cyc_addr = ip_q + 16'd2;
        end
      end
      M3_NHI: begin
        if (rd_vld) nhi_d = rd_dat;
        if (cyc_end) begin
          state_d  = M4_MLO;
          cyc_go   = 1'b1;
          cyc_addr = {nhi_q, nlo_q};
        end
      end
      M4_MLO: begin
        if (rd_vld) ltmp_d = rd_dat;
        if (cyc_end) begin
          state_d  = M5_MHI;
          cyc_go   = 1'b1;
          cyc_addr = {nhi_q, nlo_q} + 16'd1;
        end
      end
      M5_MHI: begin
        // H and L are committed together with done, entering T3.
        if (rd_vld) begin
          done_d   = 1'b1;
          reg_h_d  = rd_dat;
          reg_l_d  = ltmp_q;
          reg_ip_d = ip_q + 16'd3;
        end
        if (cyc_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    mcycle_d = mcycle_of(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ip_q      <= 16'h0000;
      op_q      <= 8'h00;
      nlo_q     <= 8'h00;
      nhi_q     <= 8'h00;
      ltmp_q    <= 8'h00;
      reg_h_q   <= 8'h00;
      reg_l_q   <= 8'h00;
      reg_ip_q  <= 16'h0000;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      mcycle_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      ip_q      <= ip_d;
      op_q      <= op_d;
      nlo_q     <= nlo_d;
      nhi_q     <= nhi_d;
      ltmp_q    <= ltmp_d;
      reg_h_q   <= reg_h_d;
      reg_l_q   <= reg_l_d;
      reg_ip_q  <= reg_ip_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
      mcycle_q  <= mcycle_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign reg_h_out  = reg_h_q;
  assign reg_l_out  = reg_l_q;
  assign reg_ip_out = reg_ip_q;
  assign mcycle     = mcycle_q;

endmodule
